rsa_modexp: RTL and testbench

Iterative modular exponentiation engine: computes `result = base^exponent mod modulus` with left-to-right square-and-multiply over a bit-serial interleaved (Blakley) modular multiplier. It is the RSA encrypt/decrypt datapath core. The controller loads an operand set, pulses `start`, and waits for `done`. Internally it steps its exponent bit index downward from MSB to LSB and sequences per-bit multiply passes with an inner bit counter.

---
 rtl/rsa_modexp.sv | 152 +++++++++++++++
 tb/tb_rsa_modexp.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rsa_modexp.sv
// rsa_modexp: base^exponent mod modulus by left-to-right square-and-multiply
// over a bit-serial interleaved (Blakley) modular multiplier.
module rsa_modexp #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] base,
   input  logic [W-1:0] exponent,
   input  logic [W-1:0] modulus,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         error
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] TOP = CW'(W - 1);

   typedef enum logic [2:0] {IDLE, REDUCE, SQUARE, MULT, DONE} state_t;

   state_t         state, nxt;
   logic [W-1:0]   b_q, e_q, n_q, acc_q;
   logic [CW-1:0]  idx_q, cnt_q;
   logic [W+1:0]   r_q;
   logic [W-1:0]   x_op, y_op;
   logic [W+1:0]   t0, t1, p;
   logic [W+1:0]   n_ext;
   logic           last;

   assign last  = (cnt_q == '0);
   assign n_ext = {2'b00, n_q};

   // Operand select; the reduction streams base as the serial operand
   // against x=1, so each step adds at most one and r stays below n.
   always_comb begin
      x_op = '0;
      y_op = '0;
      case (state)
         REDUCE: begin
            x_op = W'(1);
            y_op = b_q;
         end
         SQUARE: begin
            x_op = acc_q;
            y_op = acc_q;
         end
         MULT: begin
            x_op = acc_q;
            y_op = b_q;
         end
         default: ;
      endcase
   end

   // One interleaved step: double, conditionally add, reduce twice.
   always_comb begin
      t0 = {r_q[W:0], 1'b0} + (y_op[cnt_q] ? {2'b00, x_op} : '0);
      t1 = (t0 >= n_ext) ? t0 - n_ext : t0;
      p  = (t1 >= n_ext) ? t1 - n_ext : t1;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   // Next-state and status outputs.
   always_comb begin
      nxt  = state;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: begin
            if (start) nxt = (modulus == '0) ? DONE : REDUCE;
         end
         REDUCE: begin
            busy = 1'b1;
            if (last) nxt = SQUARE;
         end
         SQUARE: begin
            busy = 1'b1;
            if (last) begin
               if (e_q[idx_q])        nxt = MULT;
               else if (idx_q == '0)  nxt = DONE;
            end
         end
         MULT: begin
            busy = 1'b1;
            if (last) nxt = (idx_q == '0) ? DONE : SQUARE;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Operand capture, multiply pass sequencing and result update.
   always_ff @(posedge clk) begin
      if (reset) begin
         b_q    <= '0;
         e_q    <= '0;
         n_q    <= '0;
         acc_q  <= '0;
         idx_q  <= '0;
         cnt_q  <= '0;
         r_q    <= '0;
         result <= '0;
         error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  b_q   <= base;
                  e_q   <= exponent;
                  n_q   <= modulus;
                  r_q   <= '0;
                  cnt_q <= TOP;
                  idx_q <= TOP;
                  if (modulus == '0) begin
                     result <= '0;
                     error  <= 1'b1;
                  end else begin
                     error <= 1'b0;
                     acc_q <= (modulus == W'(1)) ? '0 : W'(1);
                  end
               end
            end
            REDUCE, SQUARE, MULT: begin
               if (last) begin
                  r_q   <= '0;
                  cnt_q <= TOP;
                  if (state == REDUCE) b_q   <= p[W-1:0];
                  else                 acc_q <= p[W-1:0];
                  if (nxt == DONE) result <= p[W-1:0];
                  if (state != REDUCE && nxt == SQUARE)
                     idx_q <= idx_q - CW'(1);
               end else begin
                  r_q   <= p;
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_modexp.sv
// tb_rsa_modexp: directed and random checks of rsa_modexp against a
// reference exponentiation model, with cycle-exact latency checks.
module tb_rsa_modexp;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [W-1:0] base, exponent, modulus;
   logic         busy, done, error;
   logic [W-1:0] result;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
      int           lat;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   rsa_modexp #(.W(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .base     (base),
      .exponent (exponent),
      .modulus  (modulus),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .error    (error)
   );

   function automatic int ref_exp(input int b, input int e, input int m);
      int r, bb;
      if (m == 0) return 0;
      r  = 1 % m;
      bb = b % m;
      for (int i = 0; i < W; i++) begin
         if ((e >> i) & 1) r = (r * bb) % m;
         bb = (bb * bb) % m;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // poke: cycle to re-pulse start and scramble operands (0 = none)
   // rst_at: cycle to assert reset for one cycle (0 = none)
   task automatic run_op(input int b, input int e, input int m,
                         input int poke, input int rst_at);
      exp_t x, got;
      bit   seen, busy_ok, early_done;
      int   pc;
      @(negedge clk);
      base     = W'(b);
      exponent = W'(e);
      modulus  = W'(m);
      start    = 1'b1;
      pc = 0;
      for (int i = 0; i < W; i++) pc += (e >> i) & 1;
      if (rst_at == 0) begin
         x.res = W'(ref_exp(b, e, m));
         x.err = (m == 0);
         x.lat = (m == 0) ? 1 : W * (1 + W + pc) + 1;
         sb.push_back(x);
      end
      @(posedge clk);
      #1 start = 1'b0;
      seen       = 1'b0;
      busy_ok    = 1'b1;
      early_done = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         if (poke != 0 && c == poke) begin
            start    = 1'b1;
            base     = ~base;
            exponent = ~exponent;
            modulus  = modulus ^ 8'h5a;
         end
         if (poke != 0 && c == poke + 1) start = 1'b0;
         if (rst_at != 0) begin
            if (done) early_done = 1'b1;
            if (c == rst_at) reset = 1'b1;
            if (c == rst_at + 1) begin
               reset = 1'b0;
               chk("rst_busy", int'(busy), 0);
               chk("rst_done", int'(done), 0);
               chk("rst_result", int'(result), 0);
               chk("rst_error", int'(error), 0);
               repeat (W * 4) begin
                  @(negedge clk);
                  if (done) early_done = 1'b1;
               end
               chk("rst_no_done", int'(early_done), 0);
               seen = 1'b1;
               break;
            end
         end else if (done) begin
            seen = 1'b1;
            got  = sb.pop_front();
            chk("latency", c, got.lat);
            chk("result", int'(result), int'(got.res));
            chk("error", int'(error), int'(got.err));
            chk("busy_in_done", int'(busy), 0);
            chk("busy_profile", int'(busy_ok), 1);
            break;
         end else if (busy !== (m != 0)) begin
            busy_ok = 1'b0;
         end
      end
      if (!seen) begin
         chk("timeout", 0, 1);
         if (sb.size() > 0) void'(sb.pop_front());
      end
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      base     = '0;
      exponent = '0;
      modulus  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_result", int'(result), 0);
      chk("reset_error", int'(error), 0);
      reset = 1'b0;

      run_op(9, 7, 143, 0, 0);
      run_op(48, 103, 143, 0, 0);
      run_op(200, 5, 7, 0, 0);
      run_op(7, 0, 13, 0, 0);
      run_op(7, 0, 1, 0, 0);
      run_op(3, 9, 0, 0, 0);
      run_op(5, 3, 13, 0, 0);
      run_op(9, 7, 143, 10, 0);
      run_op(48, 103, 143, 0, 40);
      run_op(5, 3, 13, 0, 0);
      run_op(255, 255, 255, 0, 0);
      run_op(255, 255, 2, 0, 0);

      for (int k = 0; k < 300; k++)
         run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(1, 255)), 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
